// File: rtl/wave_gen_dds.sv
// wave_gen_dds: phase-accumulator (DDS) waveform generator.
// Waveforms: square with programmable duty, sawtooth, ramp-down and triangle, all amplitude-scaled.
// Configuration arrives over a valid/ready handshake. It is held in a shadow set and applied at a
// phase wrap, or at once when the generator is stopped or idle in mode off.
// Optional feature macro: FG_OFFSET_EN adds cfg_offset and a saturating offset adder in stage 2.
module wave_gen_dds #(
    parameter int DATA_W  = 16,
    parameter int PHASE_W = 32,
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [2:0]         cfg_mode,
    input  logic [PHASE_W-1:0] cfg_step,
    input  logic [PRESC_W-1:0] cfg_prescaler,
    input  logic [DATA_W-1:0]  cfg_amplitude,
    input  logic [DATA_W-1:0]  cfg_duty,
`ifdef FG_OFFSET_EN
    input  logic [DATA_W-1:0]  cfg_offset,
`endif
    output logic [DATA_W-1:0]  data_out,
    output logic               data_valid,
    output logic               wrap
);

    localparam logic [2:0] MODE_OFF    = 3'd0;
    localparam logic [2:0] MODE_SQUARE = 3'd1;
    localparam logic [2:0] MODE_SAW    = 3'd2;
    localparam logic [2:0] MODE_TRI    = 3'd3;
    localparam logic [2:0] MODE_RAMP   = 3'd4;

    typedef enum logic {S_IDLE, S_PEND} state_e;

    typedef struct packed {
        logic [2:0]         mode;
        logic [PHASE_W-1:0] step;
        logic [PRESC_W-1:0] presc;
        logic [DATA_W-1:0]  amp;
        logic [DATA_W-1:0]  duty;
`ifdef FG_OFFSET_EN
        logic [DATA_W-1:0]  offset;
`endif
    } cfg_t;

    state_e               state_q, state_d;
    logic                 cfg_ready_q, cfg_ready_d;
    cfg_t                 active_q, active_d;
    cfg_t                 shadow_q, shadow_d;
    cfg_t                 cfg_in;
    logic [PRESC_W-1:0]   presc_cnt_q, presc_cnt_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [PHASE_W-1:0]   phase_sum;
    logic                 carry;
    logic                 tick;
    logic                 copy;
    logic                 wrap_q, wrap_d;

    logic [DATA_W-1:0]    p;
    logic [DATA_W-1:0]    tri_t;
    logic [DATA_W-1:0]    mult_a;
    logic [2*DATA_W-1:0]  prod;
    logic [DATA_W-1:0]    wave;

    logic                 s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0]    s1_wave_q, s1_wave_d;
    logic [DATA_W-1:0]    sample;
    logic [DATA_W-1:0]    data_out_q, data_out_d;
    logic                 data_valid_q, data_valid_d;
`ifdef FG_OFFSET_EN
    logic [DATA_W-1:0]    s1_offset_q, s1_offset_d;
    logic [DATA_W:0]      offset_sum;
`endif

    // Gather the configuration ports into one record
    always_comb begin
        cfg_in.mode   = cfg_mode;
        cfg_in.step   = cfg_step;
        cfg_in.presc  = cfg_prescaler;
        cfg_in.amp    = cfg_amplitude;
        cfg_in.duty   = cfg_duty;
`ifdef FG_OFFSET_EN
        cfg_in.offset = cfg_offset;
`endif
    end

    // Waveform shaping from the current phase and active configuration
    always_comb begin
        p      = phase_q[PHASE_W-1 -: DATA_W];
        tri_t  = p[DATA_W-1] ? ~{p[DATA_W-2:0], 1'b0} : {p[DATA_W-2:0], 1'b0};
        case (active_q.mode)
            MODE_SAW:  mult_a = p;
            MODE_TRI:  mult_a = tri_t;
            MODE_RAMP: mult_a = ~p;
            default:   mult_a = '0;
        endcase
        prod = {{DATA_W{1'b0}}, mult_a} * {{DATA_W{1'b0}}, active_q.amp};
        wave = DATA_W'(prod >> DATA_W);
        if (active_q.mode == MODE_SQUARE) begin
            wave = (p < active_q.duty) ? active_q.amp : '0;
        end
    end

    // Next-state logic: prescaler, phase accumulator, config FSM and output pipeline
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        presc_cnt_d  = presc_cnt_q;
        phase_d      = phase_q;
        active_d     = active_q;
        shadow_d     = shadow_q;
        state_d      = state_q;
        cfg_ready_d  = cfg_ready_q;
        tick         = 1'b0;
        copy         = 1'b0;
        {carry, phase_sum} = {1'b0, phase_q} + {1'b0, active_q.step};

        if (en) begin
            if (presc_cnt_q == active_q.presc) begin
                tick        = 1'b1;
                presc_cnt_d = '0;
            end else begin
                presc_cnt_d = presc_cnt_q + PRESC_W'(1);
            end
        end else begin
            presc_cnt_d = '0;
        end

        if (tick) begin
            phase_d = phase_sum;
        end
        wrap_d = tick & carry;

        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    shadow_d    = cfg_in;
                    state_d     = S_PEND;
                    cfg_ready_d = 1'b0;
                end
            end
            S_PEND: begin
                // Stopped or silent generator: apply now and restart the waveform from phase 0
                if (!en || active_q.mode == MODE_OFF) begin
                    copy        = 1'b1;
                    phase_d     = '0;
                    presc_cnt_d = '0;
                end else if (tick && carry) begin
                    copy = 1'b1;
                end
                if (copy) begin
                    active_d    = shadow_q;
                    state_d     = S_IDLE;
                    cfg_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                cfg_ready_d = 1'b1;
            end
        endcase

        // Stage 1 captures the sample of the phase that was just consumed by the tick
        s1_valid_d = tick;
        s1_wave_d  = wave;
`ifdef FG_OFFSET_EN
        // The offset travels with its sample so a config switch never mixes old wave and new offset
        s1_offset_d = active_q.offset;
        offset_sum  = {1'b0, s1_wave_q} + {1'b0, s1_offset_q};
        sample      = offset_sum[DATA_W] ? '1 : offset_sum[DATA_W-1:0];
`else
        sample      = s1_wave_q;
`endif

        // Stage 2: new samples load; otherwise hold while running and fall to 0 once stopped
        data_valid_d = s1_valid_q;
        if (s1_valid_q) begin
            data_out_d = sample;
        end else if (!en) begin
            data_out_d = '0;
        end else begin
            data_out_d = data_out_q;
        end
    end

    // All registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop updates from pre-edge values.
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cfg_ready_q  <= 1'b1;
            active_q     <= '0;
            shadow_q     <= '0;
            presc_cnt_q  <= '0;
            phase_q      <= '0;
            wrap_q       <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_wave_q    <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
`ifdef FG_OFFSET_EN
            s1_offset_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cfg_ready_q  <= cfg_ready_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            presc_cnt_q  <= presc_cnt_d;
            phase_q      <= phase_d;
            wrap_q       <= wrap_d;
            s1_valid_q   <= s1_valid_d;
            s1_wave_q    <= s1_wave_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
`ifdef FG_OFFSET_EN
            s1_offset_q  <= s1_offset_d;
`endif
        end
    end

    assign cfg_ready  = cfg_ready_q;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign wrap       = wrap_q;

endmodule
